sdm_chan_ctrl: RTL and testbench

SDM_CHAN_CTRL -- requirements
Module: sdm_chan_ctrl

---
 rtl/sdm_chan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sdm_chan_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_chan_ctrl.sv
// ----------------------------------------------------------------------------
// sdm_chan_ctrl
//
// Retune controller for a fractional-N synthesiser channel. It holds the
// current 22-bit divide word {div_n_o, sdm_in_o}. When it accepts a request,
// it ramps that word toward the requested target in steps of req_step LSBs.
// Once the target is reached, it waits SETTLE_CYC cycles and then pulses done.
// A request whose integer word is outside N_MIN..N_MAX is rejected with a
// one-cycle err pulse, and the current word is left unchanged.
//
// Handshake: req_valid/req_ready are strict valid/ready. A request transfers
// on the rising edge where both are 1. req_ready is 1 only in IDLE, so while
// a retune runs, req_valid and the request fields are not looked at.
//
// Ports
//   clk             clock, all state on rising edge
//   rst             synchronous active-high reset
//   req_valid       request present
//   req_ready       controller idle and able to accept
//   req_n[5:0]      target integer divide word
//   req_frac[15:0]  target fractional word
//   req_step[15:0]  ramp increment per cycle (0 = jump straight to target)
//   div_n_o[5:0]    integer word to divider/SDM adder
//   sdm_in_o[15:0]  fractional word to the SDM
//   sdm_nc_enable_o noise-cancel enable (off while retuning)
//   busy            retune in progress
//   done            one-cycle pulse at retune completion
//   err             one-cycle pulse when a request is rejected
//   o_dbg_state     current FSM state encoding, for observation
//
// All outputs come straight from registers. There is no input-to-output path.
// ----------------------------------------------------------------------------
module sdm_chan_ctrl #(
    parameter int SETTLE_CYC = 64,
    parameter int N_MIN      = 8,
    parameter int N_MAX      = 55,
    parameter int RST_N      = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_n,
    input  logic [15:0] req_frac,
    input  logic [15:0] req_step,
    output logic [5:0]  div_n_o,
    output logic [15:0] sdm_in_o,
    output logic        sdm_nc_enable_o,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAMP   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [21:0] RST_WORD    = {6'(RST_N), 16'h0000};
    localparam logic [9:0]  SETTLE_LAST = 10'(SETTLE_CYC - 1);

    state_t      r_state;
    logic [21:0] r_cur;
    logic [21:0] r_tgt;
    logic [15:0] r_step;
    logic [9:0]  r_cnt;
    logic        r_err;
    logic        r_nc_en;

    state_t      w_state_nxt;
    logic [21:0] w_cur_nxt;
    logic [21:0] w_tgt_nxt;
    logic [15:0] w_step_nxt;
    logic [9:0]  w_cnt_nxt;
    logic        w_err_nxt;
    logic        w_nc_nxt;

    logic        w_accept;
    logic        w_n_ok;
    logic [22:0] w_sum;
    logic [22:0] w_diff;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_n_ok   = (req_n >= 6'(N_MIN)) && (req_n <= 6'(N_MAX));

    // The ramp arithmetic is one bit wider than the word. On the way up,
    // the carry means the sum is past any 22-bit target. On the way down,
    // bit 22 set means the subtraction borrowed (underflowed).
    assign w_sum  = {1'b0, r_cur} + {7'd0, r_step};
    assign w_diff = {1'b0, r_cur} - {7'd0, r_step};

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_tgt_nxt   = r_tgt;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_nc_nxt    = r_nc_en;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_n_ok) begin
                        w_tgt_nxt   = {req_n, req_frac};
                        w_step_nxt  = req_step;
                        w_nc_nxt    = 1'b0;
                        w_state_nxt = S_RAMP;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_RAMP: begin
                if ((r_step == 16'd0) || (r_cur == r_tgt)) begin
                    w_cur_nxt   = r_tgt;
                    w_cnt_nxt   = 10'd0;
                    w_state_nxt = S_SETTLE;
                end else if (r_cur < r_tgt) begin
                    // Clamp at the target so the word never overshoots.
                    if (w_sum >= {1'b0, r_tgt}) begin
                        w_cur_nxt   = r_tgt;
                        w_cnt_nxt   = 10'd0;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_cur_nxt = w_sum[21:0];
                    end
                end else begin
                    if (w_diff[22] || (w_diff[21:0] <= r_tgt)) begin
                        w_cur_nxt   = r_tgt;
                        w_cnt_nxt   = 10'd0;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_cur_nxt = w_diff[21:0];
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            S_DONE: begin
                // Noise cancel comes back on only after a completed retune.
                w_nc_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= RST_WORD;
            r_tgt   <= RST_WORD;
            r_step  <= 16'd0;
            r_cnt   <= 10'd0;
            r_err   <= 1'b0;
            r_nc_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_tgt   <= w_tgt_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_nc_en <= w_nc_nxt;
        end
    end

    assign req_ready       = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign err             = r_err;
    assign sdm_nc_enable_o = r_nc_en;
    assign div_n_o         = r_cur[21:16];
    assign sdm_in_o        = r_cur[15:0];
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_sdm_chan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sdm_chan_ctrl
//
// Directed bench for sdm_chan_ctrl with SETTLE_CYC = 4.
// The table holds requests applied back to back from a known start word.
// Each entry gives the expected err outcome and the hand-computed number of
// RAMP cycles. Hand-written sequences cover the exact ramp values and
// abandoned retunes. They also cover requests held across busy.
// Outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_sdm_chan_ctrl;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_n;
    logic [15:0] req_frac;
    logic [15:0] req_step;
    logic [5:0]  div_n_o;
    logic [15:0] sdm_in_o;
    logic        sdm_nc_enable_o;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  n;
        logic [15:0] frac;
        logic [15:0] step;
        logic        exp_err;
        int          exp_ramp;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    sdm_chan_ctrl #(
        .SETTLE_CYC(SETTLE),
        .N_MIN(8),
        .N_MAX(55),
        .RST_N(30)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_n(req_n),
        .req_frac(req_frac),
        .req_step(req_step),
        .div_n_o(div_n_o),
        .sdm_in_o(sdm_in_o),
        .sdm_nc_enable_o(sdm_nc_enable_o),
        .busy(busy),
        .done(done),
        .err(err),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] cur_w();
        return {div_n_o, sdm_in_o};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Present one request for a single cycle. The DUT must be idle on entry.
    task automatic drive(input logic [5:0] n, input logic [15:0] frac, input logic [15:0] step);
        req_valid = 1'b1;
        req_n     = n;
        req_frac  = frac;
        req_step  = step;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic count_to_done(input int bound, output int t);
        t = 0;
        while (done !== 1'b1 && t < bound) begin
            tick();
            t++;
        end
        if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        logic [21:0] start;
        logic [21:0] tgt;
        logic [21:0] prev;
        logic [21:0] c;
        int          t;
        int          t_reach;
        bit          bad;
        v     = tbl[idx];
        start = cur_w();
        tgt   = {v.n, v.frac};
        drive(v.n, v.frac, v.step);
        if (v.exp_err) begin
            check($sformatf("v%0d_err", idx), {31'd0, err}, 32'd1);
            check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_cur_kept", idx), {10'd0, cur_w()}, {10'd0, start});
            tick();
            check($sformatf("v%0d_err_pulse", idx), {31'd0, err}, 32'd0);
        end else begin
            check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
            t       = 0;
            t_reach = -1;
            bad     = 1'b0;
            prev    = start;
            while (done !== 1'b1 && t < 3000) begin
                tick();
                t++;
                c = cur_w();
                if (start <= tgt) begin
                    if (c > tgt || c < prev) bad = 1'b1;
                end else begin
                    if (c < tgt || c > prev) bad = 1'b1;
                end
                if (t_reach < 0 && c == tgt) t_reach = t;
                prev = c;
            end
            check($sformatf("v%0d_ramp_cycles", idx), t_reach, v.exp_ramp);
            check($sformatf("v%0d_done_latency", idx), t, v.exp_ramp + SETTLE);
            check($sformatf("v%0d_final", idx), {10'd0, cur_w()}, {10'd0, tgt});
            check($sformatf("v%0d_overshoot", idx), {31'd0, bad}, 32'd0);
            tick();
            check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_idle", idx), {30'd0, busy, req_ready}, 32'd1);
            check($sformatf("v%0d_nc", idx), {31'd0, sdm_nc_enable_o}, 32'd1);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [21:0] exp_up[4];
        logic [21:0] exp_dn[3];
        int          t;
        int          pulses;
        int          errs;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_n     = 6'd0;
        req_frac  = 16'h0;
        req_step  = 16'h0;

        // Applied in order; each entry starts from the previous final word.
        // The chain starts after a reset at 30.0000.
        tbl[0] = '{6'd30, 16'h0000, 16'h0100, 1'b0, 1};   // tgt == cur
        tbl[1] = '{6'd40, 16'h1234, 16'h0000, 1'b0, 1};   // jump
        tbl[2] = '{6'd0,  16'h0000, 16'h0000, 1'b1, 0};   // below range
        tbl[3] = '{6'd63, 16'hFFFF, 16'h0001, 1'b1, 0};   // above range
        tbl[4] = '{6'd8,  16'h0000, 16'hFFFF, 1'b0, 33};  // 0x201234 down / 0xFFFF
        tbl[5] = '{6'd55, 16'hFFFF, 16'hFFFF, 1'b0, 49};  // 0x2FFFFF up / 0xFFFF
        tbl[6] = '{6'd55, 16'hFFF0, 16'h0003, 1'b0, 5};   // 15 down / 3, exact
        tbl[7] = '{6'd55, 16'hFFF0, 16'h0001, 1'b0, 1};   // tgt == cur, nonzero step
        tbl[8] = '{6'd54, 16'hFFFF, 16'h1000, 1'b0, 16};  // 0xFFF1 down / 0x1000
        tbl[9] = '{6'd55, 16'h0000, 16'h8000, 1'b0, 1};   // 1 up, step larger than gap

        // Reset state, then jump to 30.8000.
        do_reset();
        check("rst_cur", {10'd0, cur_w()}, 32'h1E0000);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("rst_nc", {31'd0, sdm_nc_enable_o}, 32'd0);
        drive(6'd30, 16'h8000, 16'h0000);
        check("jump_busy", {30'd0, busy, req_ready}, 32'd2);
        check("jump_cur_hold", {10'd0, cur_w()}, 32'h1E0000);
        check("jump_nc_off", {31'd0, sdm_nc_enable_o}, 32'd0);
        tick();
        check("jump_cur", {10'd0, cur_w()}, 32'h1E8000);
        count_to_done(100, t);
        check("jump_done_latency", t, SETTLE);
        tick();
        check("jump_done_pulse", {31'd0, done}, 32'd0);
        check("jump_nc_on", {31'd0, sdm_nc_enable_o}, 32'd1);

        // Upward ramp 30.0000 -> 31.0000 in 0x4000 steps.
        do_reset();
        exp_up = '{22'h1E4000, 22'h1E8000, 22'h1EC000, 22'h1F0000};
        drive(6'd31, 16'h0000, 16'h4000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("up_val%0d", i), {10'd0, cur_w()}, {10'd0, exp_up[i]});
        end
        count_to_done(100, t);
        check("up_done_latency", t, SETTLE);
        check("up_final", {10'd0, cur_w()}, 32'h1F0000);
        tick();

        // Downward ramp 31.0000 -> 30.1000 in 0x5000 steps; the last step clamps.
        exp_dn = '{22'h1EB000, 22'h1E6000, 22'h1E1000};
        drive(6'd30, 16'h1000, 16'h5000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dn_val%0d", i), {10'd0, cur_w()}, {10'd0, exp_dn[i]});
        end
        pulses = 0;
        for (int i = 0; i < SETTLE + 6; i++) begin
            tick();
            if (done === 1'b1) pulses++;
            if (cur_w() != 22'h1E1000) pulses += 100;
        end
        check("dn_done_once_no_move", pulses, 1);

        // Rejected requests at the range edges.
        drive(6'd7, 16'h0000, 16'h0000);
        check("rej7_err", {31'd0, err}, 32'd1);
        check("rej7_busy", {31'd0, busy}, 32'd0);
        check("rej7_cur", {10'd0, cur_w()}, 32'h1E1000);
        tick();
        check("rej7_err_pulse", {31'd0, err}, 32'd0);
        drive(6'd56, 16'h0000, 16'h0000);
        check("rej56_err", {31'd0, err}, 32'd1);
        check("rej56_busy", {31'd0, busy}, 32'd0);
        check("rej56_cur", {10'd0, cur_w()}, 32'h1E1000);
        tick();
        check("rej56_err_pulse", {31'd0, err}, 32'd0);

        // Table-driven requests.
        do_reset();
        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset in the middle of a ramp.
        do_reset();
        tick();
        tick();
        check("mid_nc_idle_after_done", {31'd0, sdm_nc_enable_o}, 32'd0);
        drive(6'd31, 16'h0000, 16'h1000);
        tick();
        tick();
        tick();
        check("mid_cur_ramping", {10'd0, cur_w()}, 32'h1E3000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_cur_reset", {10'd0, cur_w()}, 32'h1E0000);
        check("mid_state", {29'd0, busy, done, req_ready}, 32'd1);
        check("mid_nc", {31'd0, sdm_nc_enable_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("mid_no_done", pulses, 0);

        // Request held high across busy; the fields change while busy.
        do_reset();
        req_valid = 1'b1;
        req_n     = 6'd40;
        req_frac  = 16'h0000;
        req_step  = 16'h0000;
        tick();
        check("hold_accept1", {30'd0, busy, req_ready}, 32'd2);
        req_n = 6'd7;
        errs  = 0;
        tick();
        if (err === 1'b1) errs++;
        req_n = 6'd45;
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            tick();
            t++;
            if (err === 1'b1) errs++;
        end
        check("hold_done_seen", {31'd0, done}, 32'd1);
        check("hold_no_err", errs, 0);
        check("hold_cur1", {10'd0, cur_w()}, 32'h280000);
        tick();
        check("hold_idle_gap", {30'd0, busy, req_ready}, 32'd1);
        check("hold_nc_gap", {31'd0, sdm_nc_enable_o}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("hold_accept2", {30'd0, busy, req_ready}, 32'd2);
        check("hold_nc_off2", {31'd0, sdm_nc_enable_o}, 32'd0);
        count_to_done(100, t);
        check("hold_done_latency2", t, SETTLE + 1);
        check("hold_cur2", {10'd0, cur_w()}, 32'h2D0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
